// File: rtl/npu_mem_loader.sv
`timescale 1ns/1ps
// npu_mem_loader: preload engine for the NPU on-chip memories.
// A run writes img_len host words into the image lane banks. It then unpacks
// further words byte-serially, lane 0 (MSB) first: conv_len bytes go to the
// conv RAM and dense_len bytes go to the dense RAM.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   start, abort                  run request / synchronous return to IDLE
//   img_len, conv_len, dense_len  per-run region lengths (latched on start)
//   in_data, in_valid, in_ready   host word stream (valid/ready)
//   img_addr, img_data, img_wren  image bank write port (shared by all lanes)
//   seq_addr, seq_data            conv/dense byte write port
//   conv_wren, dense_wren         conv/dense write strobes
//   busy, done, len_err           run status
module npu_mem_loader #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_AW = 14,
  parameter int unsigned SEQ_AW = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [IMG_AW:0]         img_len,
  input  logic [SEQ_AW:0]         conv_len,
  input  logic [SEQ_AW:0]         dense_len,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [IMG_AW-1:0]       img_addr,
  output logic [LANES*DATA_W-1:0] img_data,
  output logic                    img_wren,
  output logic [SEQ_AW-1:0]       seq_addr,
  output logic [DATA_W-1:0]       seq_data,
  output logic                    conv_wren,
  output logic                    dense_wren,
  output logic                    busy,
  output logic                    done,
  output logic                    len_err
);

  localparam int unsigned WW = LANES * DATA_W;
  localparam int unsigned CW = ((IMG_AW > SEQ_AW) ? IMG_AW : SEQ_AW) + 1;
  localparam int unsigned LW = $clog2(LANES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_IMAGE, S_CONV, S_DENSE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [IMG_AW:0]     img_len_q, img_len_d;
  logic [SEQ_AW:0]     conv_len_q, conv_len_d;
  logic [SEQ_AW:0]     dense_len_q, dense_len_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WW-1:0]       sbuf_q, sbuf_d;
  logic [LW-1:0]       rem_q, rem_d;
  logic                in_ready_q, in_ready_d;
  logic [IMG_AW-1:0]   img_addr_q, img_addr_d;
  logic [WW-1:0]       img_data_q, img_data_d;
  logic                img_wren_q, img_wren_d;
  logic [SEQ_AW-1:0]   seq_addr_q, seq_addr_d;
  logic [DATA_W-1:0]   seq_data_q, seq_data_d;
  logic                conv_wren_q, conv_wren_d;
  logic                dense_wren_q, dense_wren_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                len_err_q, len_err_d;

  logic                beat_acc;
  logic                len_bad;
  logic                emit;
  logic [DATA_W-1:0]   emit_byte;
  logic [SEQ_AW:0]     seq_len;

  assign beat_acc = in_valid && in_ready_q;

  // A length is illegal when it exceeds 2^AW (top bit set with any lower bit set).
  assign len_bad = (img_len[IMG_AW]   && (|img_len[IMG_AW-1:0]))   ||
                   (conv_len[SEQ_AW]  && (|conv_len[SEQ_AW-1:0]))  ||
                   (dense_len[SEQ_AW] && (|dense_len[SEQ_AW-1:0]));

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state_q;
    img_len_d    = img_len_q;
    conv_len_d   = conv_len_q;
    dense_len_d  = dense_len_q;
    cnt_d        = cnt_q;
    sbuf_d       = sbuf_q;
    rem_d        = rem_q;
    img_addr_d   = img_addr_q;
    img_data_d   = img_data_q;
    img_wren_d   = 1'b0;
    seq_addr_d   = seq_addr_q;
    seq_data_d   = seq_data_q;
    conv_wren_d  = 1'b0;
    dense_wren_d = 1'b0;
    len_err_d    = len_err_q;
    emit         = 1'b0;
    emit_byte    = '0;
    seq_len      = (state_q == S_CONV) ? conv_len_q : dense_len_q;

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sbuf_d  = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            img_len_d   = img_len;
            conv_len_d  = conv_len;
            dense_len_d = dense_len;
            if (len_bad) begin
              len_err_d = 1'b1;
            end else begin
              len_err_d = 1'b0;
              cnt_d     = '0;
              sbuf_d    = '0;
              rem_d     = '0;
              state_d   = (img_len   != '0) ? S_IMAGE :
                          (conv_len  != '0) ? S_CONV  :
                          (dense_len != '0) ? S_DENSE : S_DONE;
            end
          end
        end
        S_IMAGE: begin
          if (beat_acc) begin
            img_addr_d = cnt_q[IMG_AW-1:0];
            img_data_d = in_data;
            img_wren_d = 1'b1;
            if (cnt_q == CW'(img_len_q) - CW'(1)) begin
              cnt_d   = '0;
              state_d = (conv_len_q  != '0) ? S_CONV  :
                        (dense_len_q != '0) ? S_DENSE : S_DONE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_CONV, S_DENSE: begin
          // Drain buffered lanes first; a fresh beat goes straight out as lane 0.
          if (rem_q != '0) begin
            emit      = 1'b1;
            emit_byte = sbuf_q[WW-1 -: DATA_W];
            sbuf_d    = sbuf_q << DATA_W;
            rem_d     = rem_q - LW'(1);
          end else if (beat_acc) begin
            emit      = 1'b1;
            emit_byte = in_data[WW-1 -: DATA_W];
            sbuf_d    = in_data << DATA_W;
            rem_d     = LW'(LANES - 1);
          end
          if (emit) begin
            seq_addr_d   = cnt_q[SEQ_AW-1:0];
            seq_data_d   = emit_byte;
            conv_wren_d  = (state_q == S_CONV);
            dense_wren_d = (state_q == S_DENSE);
            if (cnt_q == CW'(seq_len) - CW'(1)) begin
              // Region complete: leftover lanes of this beat are dropped.
              cnt_d   = '0;
              sbuf_d  = '0;
              rem_d   = '0;
              state_d = (state_q == S_CONV && dense_len_q != '0) ? S_DENSE : S_DONE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d     = (state_d == S_IMAGE) || (state_d == S_CONV) || (state_d == S_DENSE);
    done_d     = (state_d == S_DONE);
    // Sequential regions take a new beat only once the unpack buffer is drained.
    in_ready_d = (state_d == S_IMAGE) ||
                 (((state_d == S_CONV) || (state_d == S_DENSE)) && (rem_d == '0));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      img_len_q    <= '0;
      conv_len_q   <= '0;
      dense_len_q  <= '0;
      cnt_q        <= '0;
      sbuf_q       <= '0;
      rem_q        <= '0;
      in_ready_q   <= 1'b0;
      img_addr_q   <= '0;
      img_data_q   <= '0;
      img_wren_q   <= 1'b0;
      seq_addr_q   <= '0;
      seq_data_q   <= '0;
      conv_wren_q  <= 1'b0;
      dense_wren_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      img_len_q    <= img_len_d;
      conv_len_q   <= conv_len_d;
      dense_len_q  <= dense_len_d;
      cnt_q        <= cnt_d;
      sbuf_q       <= sbuf_d;
      rem_q        <= rem_d;
      in_ready_q   <= in_ready_d;
      img_addr_q   <= img_addr_d;
      img_data_q   <= img_data_d;
      img_wren_q   <= img_wren_d;
      seq_addr_q   <= seq_addr_d;
      seq_data_q   <= seq_data_d;
      conv_wren_q  <= conv_wren_d;
      dense_wren_q <= dense_wren_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      len_err_q    <= len_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign img_addr   = img_addr_q;
  assign img_data   = img_data_q;
  assign img_wren   = img_wren_q;
  assign seq_addr   = seq_addr_q;
  assign seq_data   = seq_data_q;
  assign conv_wren  = conv_wren_q;
  assign dense_wren = dense_wren_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_npu_mem_loader.sv
`timescale 1ns/1ps
// Self-checking bench for npu_mem_loader. Each run builds the expected write
// streams from the region lengths and the beat list, then checks every
// observed strobe, the status flags and the handshake against them.
module tb_npu_mem_loader;
  localparam int L   = 4;
  localparam int DW  = 8;
  localparam int IAW = 14;
  localparam int SAW = 16;
  localparam int WW  = L * DW;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [IAW:0]   img_len = '0;
  logic [SAW:0]   conv_len = '0;
  logic [SAW:0]   dense_len = '0;
  logic [WW-1:0]  in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [IAW-1:0] img_addr;
  logic [WW-1:0]  img_data;
  logic           img_wren;
  logic [SAW-1:0] seq_addr;
  logic [DW-1:0]  seq_data;
  logic           conv_wren;
  logic           dense_wren;
  logic           busy;
  logic           done;
  logic           len_err;

  int n_vec = 0;
  int n_err = 0;

  logic [WW-1:0] beats[$];
  int            exp_ia[$];
  logic [WW-1:0] exp_id[$];
  int            exp_ca[$];
  logic [DW-1:0] exp_cd[$];
  int            exp_da[$];
  logic [DW-1:0] exp_dd[$];
  int            sbytes[$];

  npu_mem_loader #(.LANES(L), .DATA_W(DW), .IMG_AW(IAW), .SEQ_AW(SAW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .img_len(img_len), .conv_len(conv_len), .dense_len(dense_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .img_addr(img_addr), .img_data(img_data), .img_wren(img_wren),
    .seq_addr(seq_addr), .seq_data(seq_data),
    .conv_wren(conv_wren), .dense_wren(dense_wren),
    .busy(busy), .done(done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane_of(input logic [WW-1:0] w, input int k);
    return w[(L-1-k)*DW +: DW];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_img_addr"}, img_addr, 0);
    chk({tag, "_img_data"}, img_data, 0);
    chk({tag, "_img_wren"}, img_wren, 0);
    chk({tag, "_seq_addr"}, seq_addr, 0);
    chk({tag, "_seq_data"}, seq_data, 0);
    chk({tag, "_conv_wren"}, conv_wren, 0);
    chk({tag, "_dense_wren"}, dense_wren, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_len_err"}, len_err, 0);
  endtask

  // One complete run: il image beats, cl conv bytes, dl dense bytes.
  // vprob is the percentage of cycles in which a pending beat is offered.
  task automatic run(input int il, input int cl, input int dl, input int vprob, input bit preset);
    int ncb, ndb, idx, img_acc, pending, first_seq, last_seq, budget;
    bit fin;
    ncb = (cl + L - 1) / L;
    ndb = (dl + L - 1) / L;
    if (!preset) begin
      beats.delete();
      for (int i = 0; i < il + ncb + ndb; i++) beats.push_back($urandom);
    end
    exp_ia.delete(); exp_id.delete(); exp_ca.delete(); exp_cd.delete();
    exp_da.delete(); exp_dd.delete(); sbytes.delete();
    for (int n = 0; n < il; n++) begin
      exp_ia.push_back(n);
      exp_id.push_back(beats[n]);
    end
    for (int k = 0; k < cl; k++) begin
      exp_ca.push_back(k);
      exp_cd.push_back(lane_of(beats[il + k / L], k % L));
    end
    for (int k = 0; k < dl; k++) begin
      exp_da.push_back(k);
      exp_dd.push_back(lane_of(beats[il + ncb + k / L], k % L));
    end
    for (int j = 0; j < ncb; j++) sbytes.push_back((cl - j * L) < L ? cl - j * L : L);
    for (int j = 0; j < ndb; j++) sbytes.push_back((dl - j * L) < L ? dl - j * L : L);

    @(negedge clk);
    start     = 1'b1;
    img_len   = (IAW+1)'(il);
    conv_len  = (SAW+1)'(cl);
    dense_len = (SAW+1)'(dl);
    in_valid  = 1'b0;

    idx = 0; img_acc = 0; pending = 0; first_seq = -1; last_seq = -1; fin = 1'b0;
    budget = 200 + 12 * (il + cl + dl);
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (img_wren) begin
        if (exp_ia.size() == 0) chk("img_spurious_write", 1, 0);
        else begin
          chk("img_addr", img_addr, exp_ia.pop_front());
          chk("img_data", img_data, exp_id.pop_front());
        end
      end
      if (conv_wren) begin
        if (exp_ca.size() == 0) chk("conv_spurious_write", 1, 0);
        else begin
          chk("conv_addr", seq_addr, exp_ca.pop_front());
          chk("conv_data", seq_data, exp_cd.pop_front());
          pending--;
          if (first_seq < 0) first_seq = cyc;
          last_seq = cyc;
        end
      end
      if (dense_wren) begin
        if (exp_da.size() == 0) chk("dense_spurious_write", 1, 0);
        else begin
          chk("dense_addr", seq_addr, exp_da.pop_front());
          chk("dense_data", seq_data, exp_dd.pop_front());
          pending--;
          if (first_seq < 0) first_seq = cyc;
          last_seq = cyc;
        end
      end
      fin = (exp_ia.size() == 0) && (exp_ca.size() == 0) && (exp_da.size() == 0);
      chk("done", done, fin);
      chk("busy", busy, !fin);
      chk("len_err", len_err, 0);
      if (img_acc < il) chk("in_ready_image", in_ready, 1);
      else              chk("in_ready_seq", in_ready, !fin && pending == 0);
      if (!fin && idx < beats.size() && $urandom_range(99) < vprob) begin
        in_valid = 1'b1;
        in_data  = beats[idx];
        if (in_ready) begin
          if (idx < il) img_acc++;
          else          pending += sbytes[idx - il];
          idx++;
        end
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end
    end
    if (!fin) chk("run_timeout", 0, 1);
    if (vprob >= 100 && (cl + dl) > 0)
      chk("seq_throughput_span", last_seq - first_seq, cl + dl - 1);

    // Beats offered in DONE must be ignored.
    in_valid = 1'b1;
    in_data  = $urandom;
    repeat (2) begin
      @(negedge clk);
      chk("done_no_write", img_wren | conv_wren | dense_wren, 0);
      chk("done_in_ready", in_ready, 0);
      chk("done_hold", done, 1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset values, and valid ignored while IDLE.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("idle_no_write", img_wren | conv_wren | dense_wren, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    in_valid = 1'b0;

    // Directed image-only run.
    beats = {32'hAABBCCDD, 32'h11223344, 32'h55667788};
    run(3, 0, 0, 100, 1'b1);

    // Directed mixed run with dropped lanes at the end of conv.
    beats = {32'hDEADBEEF, 32'h01020304, 32'h05060708, 32'h0A0B0C0D};
    run(1, 6, 4, 100, 1'b1);

    // Conv with gappy valid.
    repeat (4) run(0, $urandom_range(1, 40), 0, 50, 1'b0);

    // Random mixes, including zero-length regions.
    repeat (8) run($urandom_range(0, 6), $urandom_range(0, 13), $urandom_range(0, 13),
                   $urandom_range(30, 100), 1'b0);
    run(0, 0, 0, 100, 1'b0);

    // Length error handling.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_done_clear", done, 0);
    chk("abort_busy", busy, 0);
    start = 1'b1; img_len = '0; conv_len = (SAW+1)'((1 << SAW) + 1); dense_len = '0;
    @(negedge clk); start = 1'b0;
    chk("conv_len_err", len_err, 1);
    chk("conv_len_err_busy", busy, 0);
    chk("conv_len_err_ready", in_ready, 0);
    chk("conv_len_err_done", done, 0);
    start = 1'b1; img_len = (IAW+1)'((1 << IAW) + 1); conv_len = '0;
    @(negedge clk); start = 1'b0;
    chk("img_len_err", len_err, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_keeps_len_err", len_err, 1);
    start = 1'b1; img_len = '0; conv_len = (SAW+1)'(1 << SAW);
    @(negedge clk); start = 1'b0;
    chk("max_len_ok", len_err, 0);
    chk("max_len_busy", busy, 1);
    chk("max_len_ready", in_ready, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_idle", busy, 0);
    run(2, 3, 0, 100, 1'b0);

    // Abort mid-DENSE together with an accepted-looking beat.
    @(negedge clk);
    start = 1'b1; img_len = '0; conv_len = '0; dense_len = (SAW+1)'(8);
    @(negedge clk); start = 1'b0;
    chk("dense_first_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 32'hC0C1C2C3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_pre_wren", dense_wren, 1);
      chk("abort_pre_addr", seq_addr, i);
      chk("abort_pre_data", seq_data, 'hC0 + i);
      chk("abort_pre_ready", in_ready, i == 3);
      in_valid = (i == 3);
      abort    = (i == 3);
      in_data  = 32'hD0D1D2D3;
    end
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_no_write", dense_wren, 0);
    chk("abort_busy_low", busy, 0);
    chk("abort_ready_low", in_ready, 0);
    chk("abort_done_low", done, 0);
    @(negedge clk);
    chk("abort_still_no_write", dense_wren, 0);
    run(0, 0, 4, 100, 1'b0);

    // Asynchronous reset between clock edges during CONV.
    @(negedge clk);
    start = 1'b1; img_len = '0; conv_len = (SAW+1)'(20); dense_len = '0;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1; in_data = 32'h8899AABB;
    repeat (3) @(negedge clk);
    chk("pre_reset_conv_wren", conv_wren, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    in_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_ready", in_ready, 0);
    chk("post_reset_done", done, 0);
    run(0, 5, 3, 70, 1'b0);

    // Full-depth image region ends at the last address.
    run(1 << IAW, 0, 0, 100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/npu_mem_loader.md
# npu_mem_loader

Parametrised preload engine for NPU on-chip memories. Streams host words into image lane banks, then unpacks further words byte-serially into the conv-weight and dense-weight RAMs. Region lengths are programmable per run. Sits between the Avalon register front end and the image/conv/dense RAM instances. Adds over the fixed-count loader:
- valid/ready flow control;
- a width converter for the sequential regions;
- abort, zero-length skip and a length error check.

## Interface
Parameters:
- LANES, 4, image banks / bytes per input word
- DATA_W, 8, bits per byte lane
- IMG_AW, 14, image bank address width
- SEQ_AW, 16, conv/dense RAM address width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request; sampled only in IDLE or DONE
- abort  in  1  synchronous; returns to IDLE from any state
- img_len  in  IMG_AW+1  image beats to write (0..2^IMG_AW)
- conv_len  in  SEQ_AW+1  conv bytes to write (0..2^SEQ_AW)
- dense_len  in  SEQ_AW+1  dense bytes to write (0..2^SEQ_AW)
- in_data  in  LANES*DATA_W  host word; lane 0 = most significant byte
- in_valid  in  1  in_data valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- img_addr  out  IMG_AW  shared address for all image banks
- img_data  out  LANES*DATA_W  lane i drives bank i
- img_wren  out  1  write strobe for all image banks
- seq_addr  out  SEQ_AW  conv/dense RAM address
- seq_data  out  DATA_W  conv/dense write byte
- conv_wren  out  1  conv RAM write strobe
- dense_wren  out  1  dense RAM write strobe
- busy  out  1  state is IMAGE, CONV or DENSE
- done  out  1  state is DONE
- len_err  out  1  last start was rejected for an illegal length

## Operation
- States: IDLE, IMAGE, CONV, DENSE, DONE.
- start in IDLE or DONE:
  - Latches the three lengths.
  - If img_len > 2^IMG_AW, or conv_len or dense_len > 2^SEQ_AW: set len_err = 1 and stay in place.
  - Otherwise clear len_err and go to the first region with nonzero length, in order IMAGE, CONV, DENSE. If all three are zero, go to DONE.
- start in any other state is ignored.
- IMAGE:
  - in_ready = 1.
  - Each accepted beat n (from 0) writes in_data at img_addr = n.
  - After beat img_len-1, go to the next nonzero region, or DONE if none.
- CONV and DENSE:
  - One-word unpack buffer holds one beat.
  - An accepted beat is emitted one byte per cycle, lane 0 first.
  - Byte k of the region is written at seq_addr = k, starting from 0 in each region.
  - in_ready = 1 when the buffer is empty or is emitting its last lane, so a continuous stream sustains 1 byte/cycle.
  - After byte len-1 the region ends. Unused lanes of the final beat are discarded; the buffer is cleared.
  - CONV goes to DENSE if dense_len != 0, else DONE. DENSE goes to DONE.
- in_ready = 0 in IDLE and DONE. in_valid there is ignored.
- DONE holds done = 1 until the next start or abort.
- abort has priority over start and over a data beat in the same cycle. Next cycle: state IDLE, all wrens 0, buffer cleared, len_err unchanged.
- Reset (async): state IDLE. All outputs 0: in_ready, wrens, addresses, data, busy, done, len_err.

## Timing
- All write-port outputs are registered.
- Image beat accepted at cycle t: img_wren = 1 with its addr/data at t+1.
- Sequential beat accepted at t: lane k is written at t+1+k (conv_wren or dense_wren high).
- A strobe is low in any cycle with no write; address/data hold their last value.
- start accepted at t: busy = 1 and in_ready = 1 at t+1.
- After the final write of a run, done = 1 in the same cycle as that write's strobe.
- Region change: the first beat of the next region can be accepted the cycle after the previous region's last beat (IMAGE) or last byte (CONV/DENSE) is written.
- Counters are IMG_AW+1 / SEQ_AW+1 bits wide; a full-depth region ends exactly at address 2^AW-1 with no wrap write.

## Test plan
- LANES=4, start with img_len=3, conv_len=0, dense_len=0; beats 0xAABBCCDD, 0x11223344, 0x55667788 -> img writes at addr 0,1,2 with those words; done at the third write; in_ready = 0 after.
- img_len=1, conv_len=6, dense_len=4; beats W0, then 0x01020304, 0x05060708, then 0x0A0B0C0D -> conv bytes 01..06 at addr 0..5 with 07,08 dropped; dense bytes 0A..0D at addr 0..3; continuous 1 byte/cycle, in_ready pattern 1,0,0,0,1 per beat.
- In CONV, in_valid toggled 1/0 randomly -> no lost or duplicated bytes, addresses contiguous, strobe low in gap cycles.
- conv_len = 2^SEQ_AW+1 -> len_err = 1, state IDLE; a following legal start -> len_err = 0, busy = 1.
- abort in the same cycle as a valid beat mid-DENSE -> no write next cycle; IDLE, in_ready = 0; new start writes again from addr 0.
- reset_n asserted asynchronously mid-CONV (between clock edges) -> all outputs 0 immediately; state IDLE after release.
